// File: rtl/pulse_analyzer_pkg.sv
// Shared definitions for the pulse-analysis chain (frame generator and integrator).
// Holds the frame/position defaults both ends must agree on, the state encoding,
// and width helpers for counters and pulse-window comparisons.
package pulse_analyzer_pkg;

    // Frame geometry defaults shared by generator and integrator
    localparam int unsigned DEFAULT_FRAME_LENGTH    = 1000;
    localparam int unsigned DEFAULT_PULSE_POSITION  = 100;
    localparam int unsigned DEFAULT_WIDTH           = 16;
    localparam int unsigned DEFAULT_MAX_PULSE_WIDTH = 256;
    localparam int unsigned DEFAULT_GAP_LENGTH      = 16;

    // State encoding
    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_EMIT = 2'd1;
    localparam logic [1:0] STATE_GAP  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = STATE_IDLE,
        ST_EMIT = STATE_EMIT,
        ST_GAP  = STATE_GAP
    } state_t;

    // Bits needed to count 0..count-1 (at least one bit)
    function automatic int unsigned counter_width(input int unsigned count);
        return (count <= 1) ? 1 : $clog2(count);
    endfunction

    // Width that holds position + pulse width without overflow
    function automatic int unsigned compare_width(input int unsigned frame_length,
                                                  input int unsigned max_pulse_width);
        return $clog2(frame_length + max_pulse_width) + 1;
    endfunction

endpackage

// File: rtl/frame_index_counter.sv
// Handshake-gated modulo counter with a terminal-count flag.
// Ports:
//   clk, resetn  - clock, async active-low reset
//   clear        - synchronous return to zero (has priority over advance)
//   advance      - step by one; wraps to zero after the terminal count
//   count        - current count (registered)
//   last_c       - combinational, high when count == COUNT-1
module frame_index_counter #(
    parameter int unsigned COUNT = 2,
    parameter int unsigned CNT_W = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             advance,
    output logic [CNT_W-1:0] count,
    output logic             last_c
);

    assign last_c = (count == CNT_W'(COUNT - 1));

    // Count register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (advance) begin
            count <= last_c ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pulse_frame_generator.sv
// Expands one amplitude descriptor into a frame of FRAME_LENGTH samples: a
// rectangular pulse of pulse_width samples starting at PULSE_POSITION on a
// constant baseline, followed by GAP_LENGTH idle cycles.
// Ports:
//   clk, resetn               - clock, async active-low reset
//   baseline, pulse_width     - frame config, latched with the descriptor
//   s_tvalid/s_tready/s_tdata - descriptor stream (amplitude)
//   m_tvalid/m_tready/m_tdata/m_tlast - sample stream
//   busy        - not idle
//   frame_count - completed frames, wraps
//   clip_err    - sticky, a pulse was truncated by the frame end
module pulse_frame_generator
    import pulse_analyzer_pkg::*;
#(
    parameter int unsigned FRAME_LENGTH    = DEFAULT_FRAME_LENGTH,
    parameter int unsigned PULSE_POSITION  = DEFAULT_PULSE_POSITION,
    parameter int unsigned WIDTH           = DEFAULT_WIDTH,
    parameter int unsigned MAX_PULSE_WIDTH = DEFAULT_MAX_PULSE_WIDTH,
    parameter int unsigned GAP_LENGTH      = DEFAULT_GAP_LENGTH
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic [WIDTH-1:0]                       baseline,
    input  logic [$clog2(MAX_PULSE_WIDTH+1)-1:0]   pulse_width,
    input  logic                                   s_tvalid,
    output logic                                   s_tready,
    input  logic [WIDTH-1:0]                       s_tdata,
    output logic                                   m_tvalid,
    input  logic                                   m_tready,
    output logic [WIDTH-1:0]                       m_tdata,
    output logic                                   m_tlast,
    output logic                                   busy,
    output logic [31:0]                            frame_count,
    output logic                                   clip_err
);

    localparam int unsigned PW_W    = $clog2(MAX_PULSE_WIDTH + 1);
    localparam int unsigned IDX_W   = counter_width(FRAME_LENGTH);
    localparam int unsigned CMP_W   = compare_width(FRAME_LENGTH, MAX_PULSE_WIDTH);
    localparam int unsigned GAP_CNT = (GAP_LENGTH == 0) ? 1 : GAP_LENGTH;
    localparam int unsigned GAP_W   = counter_width(GAP_CNT);
    localparam bit          HAS_GAP = (GAP_LENGTH > 0);

    state_t            state;
    logic [WIDTH-1:0]  amplitude_q;
    logic [WIDTH-1:0]  base_q;
    logic [PW_W-1:0]   pw_q;

    logic [IDX_W-1:0]  index;
    logic              index_last_c;
    logic [IDX_W-1:0]  next_index_c;
    logic [GAP_W-1:0]  gap_count;
    logic              gap_last_c;

    logic              accept_c;
    logic              beat_c;
    logic              frame_done_c;
    logic [PW_W-1:0]   pw_clamped_c;
    logic              clip_c;

    // True when idx falls inside [PULSE_POSITION, PULSE_POSITION+pw)
    function automatic logic in_pulse(input logic [IDX_W-1:0] idx,
                                      input logic [PW_W-1:0]  pw);
        logic [CMP_W-1:0] lo;
        logic [CMP_W-1:0] hi;
        logic [CMP_W-1:0] pos;
        lo  = CMP_W'(PULSE_POSITION);
        hi  = lo + CMP_W'(pw);
        pos = CMP_W'(idx);
        return (pos >= lo) && (pos < hi);
    endfunction

    // Handshakes and descriptor pre-processing
    assign accept_c     = s_tvalid && s_tready;
    assign beat_c       = m_tvalid && m_tready;
    assign frame_done_c = beat_c && index_last_c;
    assign next_index_c = index + IDX_W'(1);
    assign pw_clamped_c = (pulse_width > PW_W'(MAX_PULSE_WIDTH))
                        ? PW_W'(MAX_PULSE_WIDTH) : pulse_width;
    // Pulse would run past the frame; the in_pulse window truncates it naturally
    assign clip_c       = (CMP_W'(PULSE_POSITION) + CMP_W'(pw_clamped_c))
                        > CMP_W'(FRAME_LENGTH);

    // Sample index within the frame, advanced per accepted beat
    frame_index_counter #(
        .COUNT (FRAME_LENGTH),
        .CNT_W (IDX_W)
    ) u_index_counter (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (accept_c),
        .advance (beat_c),
        .count   (index),
        .last_c  (index_last_c)
    );

    // Inter-frame gap timer
    frame_index_counter #(
        .COUNT (GAP_CNT),
        .CNT_W (GAP_W)
    ) u_gap_timer (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (frame_done_c),
        .advance (state == ST_GAP),
        .count   (gap_count),
        .last_c  (gap_last_c)
    );

    // Gap timer wraps to zero exactly as the gap ends, so it rests at zero elsewhere
    always_comb begin : gap_timer_check
        if (resetn && state != ST_GAP) begin
            assert (gap_count == '0);
        end
    end

    // Frame FSM; every output is registered and prepared for the next cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            amplitude_q <= '0;
            base_q      <= '0;
            pw_q        <= '0;
            s_tready    <= 1'b1;
            m_tvalid    <= 1'b0;
            m_tdata     <= '0;
            m_tlast     <= 1'b0;
            busy        <= 1'b0;
            frame_count <= '0;
            clip_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        amplitude_q <= s_tdata;
                        base_q      <= baseline;
                        pw_q        <= pw_clamped_c;
                        // First sample comes straight from the accepted inputs
                        m_tdata     <= in_pulse(IDX_W'(0), pw_clamped_c) ? s_tdata : baseline;
                        m_tlast     <= 1'b0;
                        m_tvalid    <= 1'b1;
                        s_tready    <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ST_EMIT;
                        if (clip_c) begin
                            clip_err <= 1'b1;
                        end
                    end
                end

                ST_EMIT: begin
                    if (frame_done_c) begin
                        frame_count <= frame_count + 32'd1;
                        m_tvalid    <= 1'b0;
                        m_tlast     <= 1'b0;
                        if (HAS_GAP) begin
                            state <= ST_GAP;
                        end else begin
                            state    <= ST_IDLE;
                            s_tready <= 1'b1;
                            busy     <= 1'b0;
                        end
                    end else if (beat_c) begin
                        m_tdata <= in_pulse(next_index_c, pw_q) ? amplitude_q : base_q;
                        m_tlast <= (next_index_c == IDX_W'(FRAME_LENGTH - 1));
                    end
                end

                ST_GAP: begin
                    if (gap_last_c) begin
                        state    <= ST_IDLE;
                        s_tready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    s_tready <= 1'b1;
                    m_tvalid <= 1'b0;
                    m_tlast  <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
